// File: rtl/control_pkg.sv
// Shared opcode, ALU-op and step-state definitions for the control sequencer.
package control_pkg;

    // Non-ALU opcodes (ir MSB = 0)
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_DATA  = 3'b010;
    localparam logic [2:0] OP_JMPR  = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b100;
    localparam logic [2:0] OP_JCOND = 3'b101;
    localparam logic [2:0] OP_CLF   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // ALU operations (ir MSB = 1)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHR = 3'b001;
    localparam logic [2:0] ALU_SHL = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // Encoding matches the visible step number; HALTED reads as step 0
    typedef enum logic [2:0] {
        StHalted = 3'd0,
        StS1     = 3'd1,
        StS2     = 3'd2,
        StS3     = 3'd3,
        StS4     = 3'd4,
        StS5     = 3'd5,
        StS6     = 3'd6
    } step_e;

    // One-hot instruction class
    typedef struct packed {
        logic alu;
        logic cmp;
        logic load;
        logic store;
        logic data;
        logic jmpr;
        logic jmp;
        logic jcond;
        logic clf;
        logic halt;
    } instr_cls_t;

endpackage

// File: rtl/opcode_decoder.sv
// Classifies the instruction from its top four bits and gives its last step.
module opcode_decoder
    import control_pkg::*;
(
    input  logic [3:0] ir_hi_i,
    output instr_cls_t cls_o,
    output step_e      last_step_o
);

    // One-hot class from ALU bit and opcode field
    always_comb begin
        cls_o = '0;
        if (ir_hi_i[3]) begin
            if (ir_hi_i[2:0] == ALU_CMP) cls_o.cmp = 1'b1;
            else                         cls_o.alu = 1'b1;
        end else begin
            unique case (ir_hi_i[2:0])
                OP_LOAD:  cls_o.load  = 1'b1;
                OP_STORE: cls_o.store = 1'b1;
                OP_DATA:  cls_o.data  = 1'b1;
                OP_JMPR:  cls_o.jmpr  = 1'b1;
                OP_JMP:   cls_o.jmp   = 1'b1;
                OP_JCOND: cls_o.jcond = 1'b1;
                OP_CLF:   cls_o.clf   = 1'b1;
                OP_HALT:  cls_o.halt  = 1'b1;
                default:  cls_o       = '0;
            endcase
        end
    end

    // JCOND reports S6; the core ends it early at S5 when not taken
    always_comb begin
        last_step_o = StS5;
        if (cls_o.alu || cls_o.data || cls_o.jcond)      last_step_o = StS6;
        else if (cls_o.jmpr || cls_o.clf || cls_o.halt)  last_step_o = StS4;
    end

endmodule

// File: rtl/control_sequencer.sv
// Step state machine with memory-ready stalls, halt/run control and
// one-hot register enables for the 8-bit mini computer.
module control_sequencer
    import control_pkg::*;
#(
    parameter  int unsigned REG_CNT = 4,
    localparam int unsigned SEL_W   = $clog2(REG_CNT),
    localparam int unsigned IR_W    = 4 + 2 * SEL_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [IR_W-1:0]    ir_i,
    input  logic               flag_c_i,
    input  logic               flag_a_i,
    input  logic               flag_e_i,
    input  logic               flag_z_i,
    input  logic               mem_ready_i,
    input  logic               halt_req_i,
    input  logic               run_i,
    output logic               bus1_o,
    output logic               iar_en_o,
    output logic               ram_en_o,
    output logic               acc_en_o,
    output logic [REG_CNT-1:0] reg_en_o,
    output logic               ir_set_o,
    output logic               mar_set_o,
    output logic               acc_set_o,
    output logic               tmp_set_o,
    output logic               ram_set_o,
    output logic               iar_set_o,
    output logic               flags_set_o,
    output logic [REG_CNT-1:0] reg_set_o,
    output logic [2:0]         alu_op_o,
    output logic [2:0]         step_o,
    output logic               halted_o,
    output logic               instr_done_o
);

    step_e              state_q, state_d;
    logic               active_q;
    instr_cls_t         cls;
    step_e              last_step;
    logic [REG_CNT-1:0] rega_oh, regb_oh;
    logic               taken, mem_step, stall, last;

    opcode_decoder u_dec (
        .ir_hi_i     (ir_i[IR_W-1:IR_W-4]),
        .cls_o       (cls),
        .last_step_o (last_step)
    );

    localparam logic [REG_CNT-1:0] OneHot = {{(REG_CNT-1){1'b0}}, 1'b1};

    // Register selects, jump condition, stall and end-of-instruction detection
    always_comb begin
        rega_oh  = OneHot << ir_i[2*SEL_W-1:SEL_W];
        regb_oh  = OneHot << ir_i[SEL_W-1:0];
        taken    = |(ir_i[3:0] & {flag_c_i, flag_a_i, flag_e_i, flag_z_i});
        mem_step = (state_q == StS2)
                || (state_q == StS5 && (cls.load || cls.store || cls.data || cls.jmp))
                || (state_q == StS6 && cls.jcond);
        stall    = mem_step && !mem_ready_i;
        last     = (state_q != StHalted)
                && ((state_q == last_step) || (cls.jcond && state_q == StS5 && !taken));
    end

    // Next step: hold on stall, boundary goes to S1 or HALTED
    always_comb begin
        state_d = state_q;
        if (state_q == StHalted) begin
            if (!halt_req_i && run_i) state_d = StS1;
        end else if (!stall) begin
            if (last) state_d = (halt_req_i || cls.halt) ? StHalted : StS1;
            else      state_d = step_e'(state_q + 3'd1);
        end
    end

    // State register; active_q keeps the first post-reset cycle in S1 with outputs low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StS1;
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (active_q) state_q <= state_d;
        end
    end

    // Strobe and enable decode; everything is low while in or just out of reset
    always_comb begin
        bus1_o      = 1'b0;
        iar_en_o    = 1'b0;
        ram_en_o    = 1'b0;
        acc_en_o    = 1'b0;
        reg_en_o    = '0;
        ir_set_o    = 1'b0;
        mar_set_o   = 1'b0;
        acc_set_o   = 1'b0;
        tmp_set_o   = 1'b0;
        ram_set_o   = 1'b0;
        iar_set_o   = 1'b0;
        flags_set_o = 1'b0;
        reg_set_o   = '0;
        alu_op_o    = 3'b000;
        if (active_q) begin
            unique case (state_q)
                StS1: begin
                    bus1_o = 1'b1; iar_en_o = 1'b1; mar_set_o = 1'b1; acc_set_o = 1'b1;
                end
                StS2: begin
                    ram_en_o = 1'b1; ir_set_o = mem_ready_i;
                end
                StS3: begin
                    acc_en_o = 1'b1; iar_set_o = 1'b1;
                end
                StS4: begin
                    if (cls.alu || cls.cmp) begin
                        reg_en_o = regb_oh; tmp_set_o = 1'b1;
                    end else if (cls.load || cls.store) begin
                        reg_en_o = rega_oh; mar_set_o = 1'b1;
                    end else if (cls.data || cls.jcond) begin
                        bus1_o = 1'b1; iar_en_o = 1'b1; mar_set_o = 1'b1; acc_set_o = 1'b1;
                    end else if (cls.jmpr) begin
                        reg_en_o = regb_oh; iar_set_o = 1'b1;
                    end else if (cls.jmp) begin
                        iar_en_o = 1'b1; mar_set_o = 1'b1;
                    end else if (cls.clf) begin
                        bus1_o = 1'b1; flags_set_o = 1'b1;
                    end
                end
                StS5: begin
                    if (cls.alu || cls.cmp) begin
                        reg_en_o  = rega_oh;
                        alu_op_o  = ir_i[IR_W-2:IR_W-4];
                        acc_set_o = 1'b1;
                        flags_set_o = 1'b1;
                    end else if (cls.load || cls.data) begin
                        ram_en_o = 1'b1; reg_set_o = mem_ready_i ? regb_oh : '0;
                    end else if (cls.store) begin
                        reg_en_o = regb_oh; ram_set_o = mem_ready_i;
                    end else if (cls.jmp) begin
                        ram_en_o = 1'b1; iar_set_o = mem_ready_i;
                    end else if (cls.jcond) begin
                        acc_en_o = 1'b1; iar_set_o = 1'b1;
                    end
                end
                StS6: begin
                    if (cls.alu) begin
                        acc_en_o = 1'b1; reg_set_o = regb_oh;
                    end else if (cls.data) begin
                        acc_en_o = 1'b1; iar_set_o = 1'b1;
                    end else if (cls.jcond) begin
                        ram_en_o = 1'b1; iar_set_o = mem_ready_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs
    always_comb begin
        step_o       = active_q ? state_q : 3'd0;
        halted_o     = active_q && (state_q == StHalted);
        instr_done_o = active_q && last;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (REG_CNT = 4, 8-bit ir).
module tb_control_sequencer;

    logic       clk, rst_n;
    logic [7:0] ir;
    logic       flag_c, flag_a, flag_e, flag_z, mem_ready, halt_req, run;
    logic       bus1, iar_en, ram_en, acc_en, ir_set, mar_set, acc_set, tmp_set;
    logic       ram_set, iar_set, flags_set, halted, instr_done;
    logic [3:0] reg_en, reg_set;
    logic [2:0] alu_op, step;
    logic [10:0] sig;

    int errs   = 0;
    int checks = 0;

    localparam logic [10:0] BUS1 = 11'h400, IAREN = 11'h200, RAMEN = 11'h100;
    localparam logic [10:0] ACCEN = 11'h080, IRSET = 11'h040, MARSET = 11'h020;
    localparam logic [10:0] ACCSET = 11'h010, TMPSET = 11'h008, RAMSET = 11'h004;
    localparam logic [10:0] IARSET = 11'h002, FLGSET = 11'h001;
    localparam logic [10:0] F_S1 = BUS1 | IAREN | MARSET | ACCSET;

    control_sequencer #(.REG_CNT(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ir_i         (ir),
        .flag_c_i     (flag_c),
        .flag_a_i     (flag_a),
        .flag_e_i     (flag_e),
        .flag_z_i     (flag_z),
        .mem_ready_i  (mem_ready),
        .halt_req_i   (halt_req),
        .run_i        (run),
        .bus1_o       (bus1),
        .iar_en_o     (iar_en),
        .ram_en_o     (ram_en),
        .acc_en_o     (acc_en),
        .reg_en_o     (reg_en),
        .ir_set_o     (ir_set),
        .mar_set_o    (mar_set),
        .acc_set_o    (acc_set),
        .tmp_set_o    (tmp_set),
        .ram_set_o    (ram_set),
        .iar_set_o    (iar_set),
        .flags_set_o  (flags_set),
        .reg_set_o    (reg_set),
        .alu_op_o     (alu_op),
        .step_o       (step),
        .halted_o     (halted),
        .instr_done_o (instr_done)
    );

    assign sig = {bus1, iar_en, ram_en, acc_en, ir_set, mar_set, acc_set, tmp_set,
                  ram_set, iar_set, flags_set};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check one cycle's outputs, then advance to 2 ns after the next rising edge
    task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] s,
                       input logic [3:0] ren, input logic [3:0] rset, input logic dn,
                       input logic [2:0] alu);
        #1;
        chk({tag, ".step"}, step, st);
        chk({tag, ".halted"}, halted, st == 3'd0);
        chk({tag, ".strobes"}, sig, s);
        chk({tag, ".reg_en"}, reg_en, ren);
        chk({tag, ".reg_set"}, reg_set, rset);
        chk({tag, ".done"}, instr_done, dn);
        chk({tag, ".alu_op"}, alu_op, alu);
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input string tag);
        cyc({tag, ".s1"}, 3'd1, F_S1, 4'h0, 4'h0, 1'b0, 3'b000);
        cyc({tag, ".s2"}, 3'd2, RAMEN | IRSET, 4'h0, 4'h0, 1'b0, 3'b000);
        cyc({tag, ".s3"}, 3'd3, ACCEN | IARSET, 4'h0, 4'h0, 1'b0, 3'b000);
    endtask

    task automatic zero_chk(input string tag);
        #1;
        chk({tag, ".step"}, step, 3'd0);
        chk({tag, ".halted"}, halted, 1'b0);
        chk({tag, ".strobes"}, sig, 11'h000);
        chk({tag, ".reg"}, {reg_en, reg_set}, 8'h00);
        chk({tag, ".done"}, instr_done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; ir = 8'h00; mem_ready = 1'b1; halt_req = 1'b0; run = 1'b0;
        flag_c = 1'b0; flag_a = 1'b0; flag_e = 1'b0; flag_z = 1'b0;
        #2;
        zero_chk("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        // LOAD R0,R0
        ir = 8'h00;
        fetch("load");
        cyc("load.s4", 3'd4, MARSET, 4'b0001, 4'h0, 1'b0, 3'b000);
        cyc("load.s5", 3'd5, RAMEN, 4'h0, 4'b0001, 1'b1, 3'b000);

        // ALU op 000, RegA=R1, RegB=R2
        ir = 8'h86;
        fetch("alu");
        cyc("alu.s4", 3'd4, TMPSET, 4'b0100, 4'h0, 1'b0, 3'b000);
        cyc("alu.s5", 3'd5, ACCSET | FLGSET, 4'b0010, 4'h0, 1'b0, 3'b000);
        cyc("alu.s6", 3'd6, ACCEN, 4'h0, 4'b0100, 1'b1, 3'b000);

        // CMP ends at S5
        ir = 8'hF6;
        fetch("cmp");
        cyc("cmp.s4", 3'd4, TMPSET, 4'b0100, 4'h0, 1'b0, 3'b000);
        cyc("cmp.s5", 3'd5, ACCSET | FLGSET, 4'b0010, 4'h0, 1'b1, 3'b111);

        // JCOND on carry, taken
        ir = 8'h58; flag_c = 1'b1;
        fetch("jc_t");
        cyc("jc_t.s4", 3'd4, F_S1, 4'h0, 4'h0, 1'b0, 3'b000);
        cyc("jc_t.s5", 3'd5, ACCEN | IARSET, 4'h0, 4'h0, 1'b0, 3'b000);
        cyc("jc_t.s6", 3'd6, RAMEN | IARSET, 4'h0, 4'h0, 1'b1, 3'b000);

        // JCOND on carry, not taken (zero flag set but masked out)
        flag_c = 1'b0; flag_z = 1'b1;
        fetch("jc_n");
        cyc("jc_n.s4", 3'd4, F_S1, 4'h0, 4'h0, 1'b0, 3'b000);
        cyc("jc_n.s5", 3'd5, ACCEN | IARSET, 4'h0, 4'h0, 1'b1, 3'b000);
        flag_z = 1'b0;

        // LOAD R2,R3 with three stall cycles in S5: 8 cycles total
        ir = 8'h0B;
        fetch("ldst");
        cyc("ldst.s4", 3'd4, MARSET, 4'b0100, 4'h0, 1'b0, 3'b000);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ldst.wait", 3'd5, RAMEN, 4'h0, 4'h0, 1'b1, 3'b000);
        mem_ready = 1'b1;
        cyc("ldst.s5", 3'd5, RAMEN, 4'h0, 4'b1000, 1'b1, 3'b000);

        // JMPR R1 with halt_req raised in S2
        ir = 8'h31;
        cyc("jmpr.s1", 3'd1, F_S1, 4'h0, 4'h0, 1'b0, 3'b000);
        halt_req = 1'b1;
        cyc("jmpr.s2", 3'd2, RAMEN | IRSET, 4'h0, 4'h0, 1'b0, 3'b000);
        cyc("jmpr.s3", 3'd3, ACCEN | IARSET, 4'h0, 4'h0, 1'b0, 3'b000);
        cyc("jmpr.s4", 3'd4, IARSET, 4'b0010, 4'h0, 1'b1, 3'b000);
        cyc("hlt1", 3'd0, 11'h000, 4'h0, 4'h0, 1'b0, 3'b000);
        run = 1'b1;
        cyc("hlt1.prio", 3'd0, 11'h000, 4'h0, 4'h0, 1'b0, 3'b000);
        halt_req = 1'b0;
        cyc("hlt1.run", 3'd0, 11'h000, 4'h0, 4'h0, 1'b0, 3'b000);
        run = 1'b0;

        // HALT instruction
        ir = 8'h70;
        fetch("halt");
        cyc("halt.s4", 3'd4, 11'h000, 4'h0, 4'h0, 1'b1, 3'b000);
        cyc("hlt2", 3'd0, 11'h000, 4'h0, 4'h0, 1'b0, 3'b000);
        run = 1'b1;
        cyc("hlt2.run", 3'd0, 11'h000, 4'h0, 4'h0, 1'b0, 3'b000);
        run = 1'b0;

        // DATA into R2, reset asserted in S5
        ir = 8'h22;
        fetch("data");
        cyc("data.s4", 3'd4, F_S1, 4'h0, 4'h0, 1'b0, 3'b000);
        #1;
        chk("data.s5.step", step, 3'd5);
        chk("data.s5.reg_set", reg_set, 4'b0100);
        rst_n = 1'b0;
        zero_chk("midrst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        cyc("post.s1", 3'd1, F_S1, 4'h0, 4'h0, 1'b0, 3'b000);
        cyc("post.s2", 3'd2, RAMEN | IRSET, 4'h0, 4'h0, 1'b0, 3'b000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction sequencer for the 8-bit mini computer, replacing the free-running six-step control path. Holds its own step state machine, runs variable-length instructions that end at their last useful step, and stalls on a memory-ready handshake. Evaluates conditional jumps against the flags, supports a HALT instruction plus external halt/run, and drives one-hot register-file enables sized by parameter.

## Interface
- REG_CNT, 4: general registers; 4, 8 or 16. SEL_W = log2(REG_CNT).
- IR_W, 4+2*SEL_W: instruction width, derived, never overridden.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ir  in  IR_W  instruction register contents.
  - ir[IR_W-1] selects ALU.
  - ir[IR_W-2:IR_W-4] is the opcode.
  - ir[2*SEL_W-1:SEL_W] is RegA.
  - ir[SEL_W-1:0] is RegB.
  - ir[3:0] is the jump condition mask C,A,E,Z.
- flag_c, flag_a, flag_e, flag_z  in  1 each  registered ALU flags.
- mem_ready  in  1  RAM read/write completes this cycle.
- halt_req  in  1  level; stop at next instruction boundary.
- run  in  1  one-cycle pulse; leave HALTED.
- bus1, iar_en, ram_en, acc_en  out  1  bus drive enables.
- reg_en  out  REG_CNT  one-hot register drive.
- ir_set, mar_set, acc_set, tmp_set, ram_set, iar_set, flags_set  out  1  capture strobes, registers load on this clk edge.
- reg_set  out  REG_CNT  one-hot register capture.
- alu_op  out  3  ALU operation; 000 outside ALU step S5.
- step  out  3  current step: 1..6, or 0 when halted.
- halted  out  1  high in HALTED.
- instr_done  out  1  high during the last step of each instruction.

## Operation
- States: S1..S6, HALTED.
- After reset the sequencer is in S1. One step per cycle unless stalled.
- Fetch, all instructions:
  - S1: bus1, iar_en, mar_set, acc_set.
  - S2: ram_en, ir_set (memory step).
  - S3: acc_en, iar_set.
- ALU (ir MSB=1):
  - S4: RegB en, tmp_set.
  - S5: RegA en, alu_op=ir op field, acc_set, flags_set.
  - S6: acc_en, RegB set. CMP (op 111) ends at S5.
- LOAD 0000: S4 RegA en, mar_set; S5 ram_en, RegB set (memory step).
- STORE 0001: S4 RegA en, mar_set; S5 RegB en, ram_set (memory step).
- DATA 0010: S4 bus1, iar_en, mar_set, acc_set; S5 ram_en, RegB set (memory step); S6 acc_en, iar_set.
- JMPR 0011: S4 RegB en, iar_set.
- JMP 0100: S4 iar_en, mar_set; S5 ram_en, iar_set (memory step).
- JCOND 0101:
  - S4: bus1, iar_en, mar_set, acc_set.
  - S5: acc_en, iar_set.
  - taken = |(ir[3:0] & {C,A,E,Z}), sampled in S5.
  - If taken, S6: ram_en, iar_set (memory step). If not taken, the instruction ends at S5.
- CLF 0110: S4 bus1, flags_set.
- HALT 0111: S4 ends the instruction, next state HALTED.
- Memory step:
  - Enables held, state held while mem_ready=0.
  - The RAM-dependent set strobe (ir_set, reg_set, iar_set, ram_set) is asserted only in the cycle mem_ready=1.
  - Advance on that cycle.
- Instruction boundary, i.e. the last step with no stall:
  - Next state HALTED if halt_req=1 or the instruction is HALT, else S1.
- HALTED:
  - All strobes and enables 0, step=0.
  - run=1 -> S1 next cycle.
  - halt_req has priority over run when both are high.
- reg_en is the OR of the RegA/RegB decodes; at most one bit is set per step.
- reg_set is set from the RegB decode only.

## Timing
- rst low: state forced to S1 immediately.
  - Every output is forced to 0 while rst is low, including step and halted.
  - First S1 outputs appear in the cycle after rst rises.
- Outputs are a combinational decode of state, ir, flags and mem_ready. No output register.
- Unstalled latency, fetch included:
  - JMPR, CLF, HALT: 4 cycles.
  - LOAD, STORE, JMP, CMP, JCOND not taken: 5 cycles.
  - ALU, DATA, JCOND taken: 6 cycles.
  - Each mem_ready=0 cycle adds 1.
- halt_req arriving mid-instruction never truncates the instruction.
- run outside HALTED is ignored.
- A stall in S2 holds ir_set low, so ir is stable from S3 onward.

## Structure
- control_pkg holds:
  - opcode constants OP_LOAD..OP_HALT.
  - ALU op constants, including ALU_CMP=3'b111.
  - step state enum (S1..S6, HALTED).
- Sub-module opcode_decoder: combinational. Takes ir; produces one-hot instruction class and the last_step value per class.
- The sequencer core holds the state register, stall logic and strobe decode.

## Test plan
- Reset, then mem_ready=1, ir=0x00 (LOAD R0,R0) -> S1 bus1/iar_en/mar_set/acc_set; S2 ir_set; S4 reg_en=0001, mar_set; S5 reg_set=0001; instr_done in S5; back to S1.
- ir=0x86 (ALU op 000, RegA=R1, RegB=R2) -> S4 reg_en=0100, tmp_set; S5 reg_en=0010, alu_op=000, flags_set; S6 reg_set=0100. ir=0xF6 (CMP) -> ends at S5, no reg_set.
- JCOND ir=0x58 with flag_c=1 -> S6 ram_en, iar_set, 6 cycles. Same ir with flag_c=0 -> instr_done at S5, next step=1.
- LOAD with mem_ready low for 3 cycles in S5 -> step stays 5, reg_set=0 until mem_ready=1; total 8 cycles.
- halt_req raised in S2 of JMPR -> instruction completes at S4, then halted=1, step=0, all strobes 0. run pulse -> S1 next cycle. ir=0x70 (HALT) -> halted after S4.
- rst low during S5 of DATA -> all outputs 0 at once; after release, S1 outputs on the first cycle.
